// File: rtl/warp_issue_arbiter_if.sv
// Fetch, flush, busy and issue signals between the warp issue arbiter and its neighbours.
// The slave modport is the arbiter side; master is the fetch/flush/dispatcher environment.
interface warp_issue_arbiter_if #(
    parameter int WARP_W = 2
);
    logic              fetch_valid;
    logic [WARP_W-1:0] fetch_warp;
    logic [31:0]       fetch_instr;
    logic              fetch_ready;
    logic              flush_valid;
    logic [WARP_W-1:0] flush_warp;
    logic              alu_busy;
    logic              tmu_busy;
    logic              tensor_busy;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [WARP_W-1:0] issue_warp;

    modport master (
        output fetch_valid, fetch_warp, fetch_instr,
        output flush_valid, flush_warp,
        output alu_busy, tmu_busy, tensor_busy,
        input  fetch_ready, instr_valid, instr, issue_warp
    );

    modport slave (
        input  fetch_valid, fetch_warp, fetch_instr,
        input  flush_valid, flush_warp,
        input  alu_busy, tmu_busy, tensor_busy,
        output fetch_ready, instr_valid, instr, issue_warp
    );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Per-warp instruction FIFOs with a round-robin issue stage that skips warps whose
// head instruction targets a busy execution unit; one registered issue per cycle.
module warp_issue_arbiter #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_W    = 2,
    parameter int DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    warp_issue_arbiter_if.slave   bus
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]       w_head  [NUM_WARPS];
    logic [PTR_W:0]    w_count [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_elig;
    logic              w_sel_found;
    logic [WARP_W-1:0] w_sel_warp;

    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic [WARP_W-1:0] r_issue_warp;
    logic [WARP_W-1:0] r_last;

    // Opcode nibble selects the execution unit: 8/9 texture, C/D tensor, all else ALU.
    function automatic logic unit_busy(input logic [3:0] op, input logic alu,
                                       input logic tmu, input logic tensor);
        case (op)
            4'h8, 4'h9: return tmu;
            4'hC, 4'hD: return tensor;
            default:    return alu;
        endcase
    endfunction

    // Ready looks only at the registered count, so a same-cycle pop or flush does not help.
    assign bus.fetch_ready = (w_count[bus.fetch_warp] != CNT_FULL);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [31:0]      r_mem [DEPTH];
            logic [PTR_W-1:0] r_wr_ptr;
            logic [PTR_W-1:0] r_rd_ptr;
            logic [PTR_W:0]   r_count;
            logic             w_flush;
            logic             w_push;
            logic             w_pop;

            assign w_flush = bus.flush_valid && (bus.flush_warp == WARP_W'(gi));
            assign w_push  = bus.fetch_valid && bus.fetch_ready &&
                             (bus.fetch_warp == WARP_W'(gi)) && !w_flush;
            assign w_pop   = w_sel_found && (w_sel_warp == WARP_W'(gi));

            assign w_head[gi]  = r_mem[r_rd_ptr];
            assign w_count[gi] = r_count;
            assign w_elig[gi]  = (r_count != '0) && !w_flush &&
                                 !unit_busy(r_mem[r_rd_ptr][31:28], bus.alu_busy,
                                            bus.tmu_busy, bus.tensor_busy);

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.fetch_instr;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else if (w_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + CNT_ONE;
                        2'b01:   r_count <= r_count - CNT_ONE;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // Scan last+1 .. last+NUM_WARPS; the final step wraps back onto last itself.
    always_comb begin
        logic [WARP_W-1:0] idx;
        idx         = '0;
        w_sel_found = 1'b0;
        w_sel_warp  = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx = r_last + WARP_W'(k);
            if (!w_sel_found && w_elig[idx]) begin
                w_sel_found = 1'b1;
                w_sel_warp  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_issue_warp  <= '0;
            r_last        <= WARP_W'(NUM_WARPS - 1);
        end else begin
            r_instr_valid <= w_sel_found;
            if (w_sel_found) begin
                r_instr      <= w_head[w_sel_warp];
                r_issue_warp <= w_sel_warp;
                r_last       <= w_sel_warp;
            end
        end
    end

    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.issue_warp  = r_issue_warp;
endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Self-checking bench for warp_issue_arbiter: a scoreboard of expected issues in order,
// a table of unit-decode/busy vectors, and hand-written multi-cycle corner sequences.
module tb_warp_issue_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    warp_issue_arbiter_if #(.WARP_W(2)) bus();

    warp_issue_arbiter #(.NUM_WARPS(4), .WARP_W(2), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]  warp;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] word;
        logic [2:0]  busy;      // {tensor, tmu, alu}
        logic        exp_issue;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Every issue seen on the output must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.instr_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got warp %0d instr 0x%08h, required no issue",
                         bus.issue_warp, bus.instr);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", bus.instr, e.word);
                check("sb_warp", {30'd0, bus.issue_warp}, {30'd0, e.warp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_valid = 1'b0;
        bus.flush_valid = 1'b0;
        bus.flush_warp  = 2'd0;
        bus.alu_busy    = 1'b0;
        bus.tmu_busy    = 1'b0;
        bus.tensor_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_issue(input logic [1:0] w, input logic [31:0] word);
        exp_t e;
        e.warp = w;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [1:0] w, input logic [31:0] word, input bit sb);
        bus.fetch_valid = 1'b1;
        bus.fetch_warp  = w;
        bus.fetch_instr = word;
        #1;
        check("push_ready", {31'd0, bus.fetch_ready}, 32'd1);
        if (sb) expect_issue(w, word);
        tick();
        bus.fetch_valid = 1'b0;
    endtask

    initial begin
        bus.fetch_warp  = 2'd0;
        bus.fetch_instr = 32'd0;
        idle_inputs();

        vecs[0]  = '{32'h0000_0000, 3'b001, 1'b0};
        vecs[1]  = '{32'h0000_0000, 3'b110, 1'b1};
        vecs[2]  = '{32'h1000_0000, 3'b001, 1'b0};
        vecs[3]  = '{32'h2000_0000, 3'b110, 1'b1};
        vecs[4]  = '{32'h8000_0000, 3'b010, 1'b0};
        vecs[5]  = '{32'h9000_0000, 3'b010, 1'b0};
        vecs[6]  = '{32'h8000_0000, 3'b101, 1'b1};
        vecs[7]  = '{32'hC000_0000, 3'b100, 1'b0};
        vecs[8]  = '{32'hD000_0000, 3'b100, 1'b0};
        vecs[9]  = '{32'hD000_0000, 3'b011, 1'b1};
        vecs[10] = '{32'hA000_0000, 3'b001, 1'b0};
        vecs[11] = '{32'hB000_0000, 3'b110, 1'b1};
        vecs[12] = '{32'hE000_0000, 3'b001, 1'b0};
        vecs[13] = '{32'hF000_0000, 3'b100, 1'b1};
        vecs[14] = '{32'h7000_0000, 3'b001, 1'b0};

        // Reset state
        #2;
        check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_issue_warp", {30'd0, bus.issue_warp}, 32'd0);
        check("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        do_reset();

        // Single push: issue registered on the edge after the push edge, then idle
        push(2'd0, 32'h1000_0001, 1'b1);
        check("t1_not_yet", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("t1_instr", bus.instr, 32'h1000_0001);
        check("t1_warp", {30'd0, bus.issue_warp}, 32'd0);
        tick();
        check("t1_pulse_end", {31'd0, bus.instr_valid}, 32'd0);
        check("t1_instr_hold", bus.instr, 32'h1000_0001);

        // Unit decode and busy skip, one head instruction on warp 0 per vector
        for (int i = 0; i < 15; i++) begin
            {bus.tensor_busy, bus.tmu_busy, bus.alu_busy} = vecs[i].busy;
            push(2'd0, vecs[i].word | i, 1'b1);
            tick();
            check($sformatf("vec%0d_issue", i), {31'd0, bus.instr_valid},
                  {31'd0, vecs[i].exp_issue});
            idle_inputs();
            repeat (3) tick();
        end

        // Round robin over four warps with two instructions each, back to back
        do_reset();
        bus.alu_busy = 1'b1;
        for (int j = 0; j < 2; j++) begin
            for (int w = 0; w < 4; w++) begin
                push(2'(w), 32'h0000_0000 | (w << 4) | j, 1'b1);
            end
        end
        bus.alu_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t2_no_gap%0d", i), {31'd0, bus.instr_valid}, 32'd1);
        end
        tick();
        check("t2_done", {31'd0, bus.instr_valid}, 32'd0);

        // Fill warp 2 to DEPTH behind a busy tensor unit, then drain in order
        do_reset();
        bus.tensor_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(2'd2, 32'hC000_0000 + i, 1'b1);
        bus.fetch_valid = 1'b1;
        bus.fetch_warp  = 2'd2;
        bus.fetch_instr = 32'hC000_0004;
        #1;
        check("t3_full", {31'd0, bus.fetch_ready}, 32'd0);
        tick();
        bus.fetch_valid = 1'b0;
        bus.tensor_busy = 1'b0;
        #1;
        check("t3_still_full", {31'd0, bus.fetch_ready}, 32'd0);
        check("t3_no_issue", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check("t3_first", {31'd0, bus.instr_valid}, 32'd1);
        check("t3_ready_back", {31'd0, bus.fetch_ready}, 32'd1);
        repeat (4) tick();

        // TMU-busy head on warp 0 is skipped while warp 1 issues
        do_reset();
        bus.tmu_busy = 1'b1;
        push(2'd0, 32'h8000_0000, 1'b0);
        push(2'd1, 32'h0000_0005, 1'b0);
        expect_issue(2'd1, 32'h0000_0005);
        expect_issue(2'd0, 32'h8000_0000);
        check("t4_idle", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        check("t4_w1", {30'd0, bus.issue_warp}, 32'd1);
        bus.tmu_busy = 1'b0;
        tick();
        check("t4_w0_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("t4_w0", {30'd0, bus.issue_warp}, 32'd0);
        tick();

        // Flush warp 3 with a colliding push; the warp must come back empty
        do_reset();
        bus.alu_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(2'd3, 32'h3000_0000 + i, 1'b0);
        bus.fetch_valid = 1'b1;
        bus.fetch_warp  = 2'd3;
        bus.fetch_instr = 32'h3000_BEEF;
        bus.flush_valid = 1'b1;
        bus.flush_warp  = 2'd3;
        #1;
        check("t5_ready_preflush", {31'd0, bus.fetch_ready}, 32'd1);
        tick();
        bus.fetch_valid = 1'b0;
        bus.flush_valid = 1'b0;
        bus.alu_busy    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_no_issue%0d", i), {31'd0, bus.instr_valid}, 32'd0);
        end
        bus.alu_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(2'd3, 32'h3000_0010 + i, 1'b1);
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h3000_0014;
        #1;
        check("t5_full_again", {31'd0, bus.fetch_ready}, 32'd0);
        tick();
        bus.fetch_valid = 1'b0;
        bus.alu_busy    = 1'b0;
        repeat (6) tick();

        // Asynchronous reset while an issue is on the output
        do_reset();
        push(2'd0, 32'h1111_0000, 1'b1);
        push(2'd0, 32'h1111_0001, 1'b0);
        check("t6_pre", {31'd0, bus.instr_valid}, 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("t6_async_instr", bus.instr, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_quiet%0d", i), {31'd0, bus.instr_valid}, 32'd0);
        end

        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
